dcache_controller: RTL and testbench
====================================

# dcache_controller

Direct-mapped, write-back, write-allocate data cache. It answers the pipeline's memory-stage load/store requests, taking the place of the flat data memory, and stalls the pipeline through BUSYWAIT on a miss. It is the memory-side responder to the CPU's MEM-stage initiator. Behind it, it is the initiator of 128-bit block transfers to a main-memory model.

## Interface
Parameters:
- SETS, 8: number of cache lines; power of two, 2..256. IDX = log2(SETS).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  CPU load request (MEMREAD of the EX/MEM register).
- WRITE  in  1  CPU store request (MEMWRITE of the EX/MEM register).
- FUNCT3  in  3  load/store width and sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- ADDRESS  in  32  byte address. Offset is [3:0], index is [IDX+3:4], tag is [31:IDX+4].
- WRITEDATA  in  32  store data, right-aligned.
- READDATA  out  32  load result, sign- or zero-extended.
- BUSYWAIT  out  1  stall request to the pipeline.
- MEM_READ  out  1  block read request.
- MEM_WRITE  out  1  block write request.
- MEM_ADDRESS  out  28  block address (byte address [31:4]).
- MEM_WRITEDATA  out  128  victim block.
- MEM_READDATA  in  128  fill block.
- MEM_BUSYWAIT  in  1  high while main memory is still servicing a request.
- HIT_COUNT, MISS_COUNT  out  32 each  present only with DCACHE_STATS_EN.

## Operation
- Each line holds valid, dirty, tag, and a 128-bit block. On reset all valid and dirty bits are cleared and the state goes to IDLE. Block contents are not reset.
- Hit means READ|WRITE is high, the indexed line is valid, and its tag matches.
- READ and WRITE high together: treated as WRITE.
- Load path (combinational, IDLE only):
  - Select the word at ADDRESS[3:2].
  - LB/LBU take the byte at ADDRESS[1:0]. LH/LHU take the halfword at ADDRESS[1]; ADDRESS[0] is ignored.
  - Unknown FUNCT3 returns the whole word.
  - READDATA is 0 when there is no read hit.
- Store hit:
  - On the clock edge, merge the byte, halfword, or word into the selected word and set dirty.
  - Unknown FUNCT3 is treated as SW.
- FSM states:
  - IDLE: request with hit gives BUSYWAIT=0. Request with miss gives BUSYWAIT=1; go to WRITEBACK if the victim is valid and dirty, otherwise go to ALLOCATE.
  - WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={victim tag, index}, MEM_WRITEDATA=victim block. On an edge with MEM_BUSYWAIT=0, go to ALLOCATE.
  - ALLOCATE: MEM_READ=1, MEM_ADDRESS=ADDRESS[31:4]. On an edge with MEM_BUSYWAIT=0, write MEM_READDATA into the line, set the tag, set valid=1 and dirty=0, then go to IDLE.
- After returning to IDLE, the held request hits and completes normally. A store miss therefore becomes a fill followed by a store hit.
- The CPU holds READ, WRITE, FUNCT3, ADDRESS and WRITEDATA stable while BUSYWAIT=1.

## Timing
- Reset values:
  - BUSYWAIT, MEM_READ, MEM_WRITE: 0.
  - MEM_ADDRESS: 0. MEM_WRITEDATA: 0.
  - READDATA: 0. Counters: 0.
- Hit: zero wait states. READDATA is valid in the request cycle and the store commits at the end of that cycle.
- BUSYWAIT is 1 whenever state≠IDLE, and combinationally in the IDLE miss cycle.
- Clean miss with 0-wait memory: BUSYWAIT high for 2 cycles (IDLE-miss, ALLOCATE); data is available in the 3rd cycle.
- Dirty miss: +1 cycle for WRITEBACK, plus any cycles memory holds MEM_BUSYWAIT high.
- MEM_READ and MEM_WRITE are never high together. Each stays high until the edge where MEM_BUSYWAIT=0, then drops.
- RESET low mid-miss: the FSM returns to IDLE immediately, memory requests drop asynchronously, and all lines are invalidated. The interrupted writeback is lost.
- Request deasserted while in WRITEBACK or ALLOCATE: the transfer still completes. The cache returns to IDLE with no CPU-side update.

## Configuration
- DCACHE_STATS_EN defined:
  - HIT_COUNT and MISS_COUNT ports exist.
  - HIT_COUNT increments once per IDLE cycle with a hit request.
  - MISS_COUNT increments once per IDLE→WRITEBACK or IDLE→ALLOCATE transition.
  - Both wrap modulo 2^32 and reset to 0.
- Not defined: the ports and counters are absent. Cache behaviour is identical.

## Test plan
- Reset, then LW 0x00000040 with memory returning a block whose word 0 is 0xDEADBEEF and MEM_BUSYWAIT=0: BUSYWAIT is high for 2 cycles, MEM_ADDRESS=0x0000004, then READDATA=0xDEADBEEF. A second LW to the same address has BUSYWAIT=0.
- After that fill, LB 0x43 reads 0xFFFFFFDE and LBU 0x43 reads 0x000000DE. LH 0x42 reads 0xFFFFDEAD.
- SB 0x41←0x12, then LW 0x40: reads 0xDEAD12EF with no stall. The line is dirty.
- LW 0x00000140 (SETS=8, same index, different tag) with memory holding MEM_BUSYWAIT high for 3 cycles per request:
  - MEM_WRITE is seen first, with MEM_ADDRESS=0x0000004 and the victim block.
  - MEM_READ follows, with MEM_ADDRESS=0x0000014.
  - BUSYWAIT is high for 9 cycles.
- RESET pulsed low during ALLOCATE: MEM_READ drops within the same cycle, BUSYWAIT=0, and a following LW 0x40 misses.
- With DCACHE_STATS_EN, after the sequence above: HIT_COUNT and MISS_COUNT match the scoreboard count.

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache; optional stats counters under DCACHE_STATS_EN.
// Latency: hits complete in the request cycle; clean miss adds 2 stall cycles, dirty miss adds a writeback.
// Backpressure: BUSYWAIT stalls the CPU on a miss; MEM_BUSYWAIT holds the cache in WRITEBACK/ALLOCATE.
module dcache_controller #(
  parameter int SETS = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         READ,
  input  logic         WRITE,
  input  logic [2:0]   FUNCT3,
  input  logic [31:0]  ADDRESS,
  input  logic [31:0]  WRITEDATA,
  output logic [31:0]  READDATA,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [27:0]  MEM_ADDRESS,
  output logic [127:0] MEM_WRITEDATA,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  HIT_COUNT,
  output logic [31:0]  MISS_COUNT
`endif
);

  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = 28 - IDX;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_t;

  state_t           r_state, w_next;
  logic [SETS-1:0]  r_valid, r_dirty;
  logic [TAGW-1:0]  r_tag  [SETS];
  logic [127:0]     r_data [SETS];
  logic [27:0]      r_miss_addr;

  logic [IDX-1:0]   w_idx, w_fidx;
  logic [TAGW-1:0]  w_tag;
  logic [127:0]     w_line, w_store_line;
  logic [31:0]      w_word, w_load, w_store_word;
  logic             w_req, w_is_rd, w_is_wr, w_hit, w_idle, w_store_en, w_fill_en, w_miss_start;

  // Request is masked while reset is held so no stall or read data leaks out.
  assign w_req    = RESET & (READ | WRITE);
  assign w_is_wr  = WRITE;
  assign w_is_rd  = READ & ~WRITE;
  assign w_idx    = ADDRESS[IDX+3:4];
  assign w_tag    = ADDRESS[31:IDX+4];
  assign w_line   = r_data[w_idx];
  assign w_word   = w_line[{ADDRESS[3:2], 5'b0} +: 32];
  assign w_hit    = w_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_idle   = (r_state == S_IDLE);
  // The miss address is latched so a dropped request cannot redirect an in-flight transfer.
  assign w_fidx   = r_miss_addr[IDX-1:0];
  assign w_store_en   = w_idle & w_hit & w_is_wr;
  assign w_fill_en    = (r_state == S_ALLOCATE) & ~MEM_BUSYWAIT;
  assign w_miss_start = w_idle & w_req & ~w_hit;

  // Load extraction: width/sign select from the addressed word.
  always_comb begin
    w_load = w_word;
    case (FUNCT3)
      3'b000: w_load = {{24{w_word[{ADDRESS[1:0], 3'b111}]}}, w_word[{ADDRESS[1:0], 3'b000} +: 8]};
      3'b100: w_load = {24'b0, w_word[{ADDRESS[1:0], 3'b000} +: 8]};
      3'b001: w_load = ADDRESS[1] ? {{16{w_word[31]}}, w_word[31:16]} : {{16{w_word[15]}}, w_word[15:0]};
      3'b101: w_load = ADDRESS[1] ? {16'b0, w_word[31:16]} : {16'b0, w_word[15:0]};
      default: w_load = w_word;
    endcase
  end

  assign READDATA = (w_idle & w_hit & w_is_rd) ? w_load : 32'b0;

  // Store merge: byte/halfword/word into the selected word; unknown widths act as SW.
  always_comb begin
    w_store_word = WRITEDATA;
    case (FUNCT3)
      3'b000: begin
        w_store_word = w_word;
        w_store_word[{ADDRESS[1:0], 3'b000} +: 8] = WRITEDATA[7:0];
      end
      3'b001: begin
        w_store_word = w_word;
        w_store_word[{ADDRESS[1], 4'b0000} +: 16] = WRITEDATA[15:0];
      end
      default: w_store_word = WRITEDATA;
    endcase
    w_store_line = w_line;
    w_store_line[{ADDRESS[3:2], 5'b0} +: 32] = w_store_word;
  end

  // Next-state and memory-side outputs.
  always_comb begin
    w_next        = r_state;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 28'b0;
    MEM_WRITEDATA = 128'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req && !w_hit) begin
          BUSYWAIT = 1'b1;
          w_next   = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {r_tag[w_fidx], w_fidx};
        MEM_WRITEDATA = r_data[w_fidx];
        if (!MEM_BUSYWAIT) w_next = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = r_miss_addr;
        if (!MEM_BUSYWAIT) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register and miss-address capture.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_miss_addr <= 28'b0;
    end else begin
      r_state <= w_next;
      if (w_miss_start) r_miss_addr <= ADDRESS[31:4];
    end
  end

  // Valid/dirty flags: cleared by reset, set by fill or store hit.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_fill_en) begin
      r_valid[w_fidx] <= 1'b1;
      r_dirty[w_fidx] <= 1'b0;
    end else if (w_store_en) begin
      r_dirty[w_idx] <= 1'b1;
    end
  end

  // Tag and block storage; contents are left alone by reset.
  always_ff @(posedge CLK) begin
    if (w_fill_en) begin
      r_data[w_fidx] <= MEM_READDATA;
      r_tag[w_fidx]  <= r_miss_addr[27:IDX];
    end else if (w_store_en) begin
      r_data[w_idx] <= w_store_line;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  // Hit counts per IDLE hit cycle; miss counts per IDLE-to-transfer transition.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_hit_cnt  <= 32'b0;
      r_miss_cnt <= 32'b0;
    end else begin
      if (w_idle && w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss_start)    r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign HIT_COUNT  = r_hit_cnt;
  assign MISS_COUNT = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed table of hit vectors plus miss/writeback/reset sequences.
// Memory model answers block requests after a programmable number of busy cycles.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_dcache_controller;

  logic         CLK, RESET, READ, WRITE;
  logic [2:0]   FUNCT3;
  logic [31:0]  ADDRESS, WRITEDATA, READDATA;
  logic         BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA, MEM_READDATA;
`ifdef DCACHE_STATS_EN
  logic [31:0]  HIT_COUNT, MISS_COUNT;
`endif

  dcache_controller #(.SETS(8)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .FUNCT3(FUNCT3),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Main-memory model
  logic [127:0] mem [0:63];
  int mem_lat;
  int mem_cnt;
  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt < mem_lat);
  assign MEM_READDATA = mem[MEM_ADDRESS[5:0]];

  always @(posedge CLK) begin
    if (MEM_READ | MEM_WRITE) begin
      if (MEM_BUSYWAIT) mem_cnt <= mem_cnt + 1;
      else begin
        mem_cnt <= 0;
        if (MEM_WRITE) mem[MEM_ADDRESS[5:0]] = MEM_WRITEDATA;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  int checks;
  int failures;
  int exp_hits;
  int exp_miss;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Results of the last run_req
  int           m_busy;
  logic         m_saw_wb, m_saw_rd, m_wb_first, m_both, m_timeout;
  logic [27:0]  m_wb_a, m_rd_a;
  logic [127:0] m_wb_d;
  logic [31:0]  m_rdat;

  // Issue one request and hold it until the stall clears, recording the memory traffic.
  task automatic run_req(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input int latency);
    mem_lat = latency;
    READ = rd; WRITE = wr; FUNCT3 = f3; ADDRESS = addr; WRITEDATA = wdata;
    m_busy = 0; m_saw_wb = 0; m_saw_rd = 0; m_wb_first = 0; m_both = 0; m_timeout = 1;
    m_wb_a = '0; m_rd_a = '0; m_wb_d = '0; m_rdat = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (MEM_READ && MEM_WRITE) m_both = 1;
      if (MEM_WRITE && !m_saw_wb) begin
        m_saw_wb = 1; m_wb_a = MEM_ADDRESS; m_wb_d = MEM_WRITEDATA;
        if (!m_saw_rd) m_wb_first = 1;
      end
      if (MEM_READ && !m_saw_rd) begin
        m_saw_rd = 1; m_rd_a = MEM_ADDRESS;
      end
      if (!BUSYWAIT) begin
        m_rdat = READDATA; m_timeout = 0;
        break;
      end
      m_busy++;
    end
    @(posedge CLK); #1;
    READ = 0; WRITE = 0; FUNCT3 = 3'b000; ADDRESS = 0; WRITEDATA = 0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [20];

  initial begin
    checks = 0; failures = 0; exp_hits = 0; exp_miss = 0;
    mem_lat = 0;
    for (int i = 0; i < 64; i++) mem[i] = {4{i[31:0] ^ 32'hA5A5_0000}};
    mem[4]  = {32'h33333333, 32'h22222222, 32'h11223344, 32'hDEADBEEF};
    mem[20] = {32'h77777777, 32'h66666666, 32'h55555555, 32'h13579BDF};

    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h40, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h43, 32'h0,        32'hFFFFFFDE};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h43, 32'h0,        32'h000000DE};
    vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h42, 32'h0,        32'hFFFFDEAD};
    vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h42, 32'h0,        32'h0000DEAD};
    vecs[5]  = '{1'b1, 1'b0, 3'b000, 32'h40, 32'h0,        32'hFFFFFFEF};
    vecs[6]  = '{1'b1, 1'b0, 3'b001, 32'h41, 32'h0,        32'hFFFFBEEF};
    vecs[7]  = '{1'b1, 1'b0, 3'b011, 32'h40, 32'h0,        32'hDEADBEEF};
    vecs[8]  = '{1'b1, 1'b0, 3'b000, 32'h47, 32'h0,        32'h00000011};
    vecs[9]  = '{1'b0, 1'b1, 3'b000, 32'h41, 32'hFFFFFF12, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h40, 32'h0,        32'hDEAD12EF};
    vecs[11] = '{1'b0, 1'b1, 3'b001, 32'h46, 32'hAAAA5566, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 3'b010, 32'h44, 32'h0,        32'h55663344};
    vecs[13] = '{1'b0, 1'b1, 3'b010, 32'h48, 32'hCAFEF00D, 32'h0};
    vecs[14] = '{1'b0, 1'b1, 3'b011, 32'h4C, 32'h01020304, 32'h0};
    vecs[15] = '{1'b1, 1'b0, 3'b010, 32'h4C, 32'h0,        32'h01020304};
    vecs[16] = '{1'b1, 1'b1, 3'b010, 32'h4C, 32'h0BADBEEF, 32'h0};
    vecs[17] = '{1'b1, 1'b0, 3'b010, 32'h4C, 32'h0,        32'h0BADBEEF};
    vecs[18] = '{1'b1, 1'b0, 3'b010, 32'h48, 32'h0,        32'hCAFEF00D};
    vecs[19] = '{1'b0, 1'b0, 3'b010, 32'h40, 32'h0,        32'h0};

    // Reset state
    RESET = 0; READ = 0; WRITE = 0; FUNCT3 = 0; ADDRESS = 0; WRITEDATA = 0;
    @(negedge CLK); @(negedge CLK);
    chk("rst_busywait", {127'b0, BUSYWAIT}, 128'd0);
    chk("rst_mem_read", {127'b0, MEM_READ}, 128'd0);
    chk("rst_mem_write", {127'b0, MEM_WRITE}, 128'd0);
    chk("rst_mem_address", {100'b0, MEM_ADDRESS}, 128'd0);
    chk("rst_mem_writedata", MEM_WRITEDATA, 128'd0);
    chk("rst_readdata", {96'b0, READDATA}, 128'd0);
`ifdef DCACHE_STATS_EN
    chk("rst_hit_count", {96'b0, HIT_COUNT}, 128'd0);
    chk("rst_miss_count", {96'b0, MISS_COUNT}, 128'd0);
`endif
    @(posedge CLK); #1 RESET = 1;
    @(posedge CLK); #1;

    // Clean miss with zero-wait memory
    run_req(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 0);
    exp_miss++; exp_hits++;
    chk("miss1_timeout", {127'b0, m_timeout}, 128'd0);
    chk("miss1_busy_cycles", m_busy, 128'd2);
    chk("miss1_no_writeback", {127'b0, m_saw_wb}, 128'd0);
    chk("miss1_mem_address", {100'b0, m_rd_a}, 128'h4);
    chk("miss1_readdata", {96'b0, m_rdat}, 128'hDEADBEEF);

    // Single-cycle hit vectors
    for (int i = 0; i < 20; i++) begin
      READ = vecs[i].rd; WRITE = vecs[i].wr; FUNCT3 = vecs[i].f3;
      ADDRESS = vecs[i].addr; WRITEDATA = vecs[i].wdata;
      if (vecs[i].rd || vecs[i].wr) exp_hits++;
      @(negedge CLK);
      chk($sformatf("vec%0d_readdata", i), {96'b0, READDATA}, {96'b0, vecs[i].exp_rd});
      chk($sformatf("vec%0d_busywait", i), {127'b0, BUSYWAIT}, 128'd0);
      @(posedge CLK); #1;
    end
    READ = 0; WRITE = 0;

    // Dirty miss, memory busy 3 cycles per request
    run_req(1'b1, 1'b0, 3'b010, 32'h140, 32'h0, 3);
    exp_miss++; exp_hits++;
    chk("dirty_timeout", {127'b0, m_timeout}, 128'd0);
    chk("dirty_wb_first", {127'b0, m_wb_first}, 128'd1);
    chk("dirty_saw_read", {127'b0, m_saw_rd}, 128'd1);
    chk("dirty_never_both", {127'b0, m_both}, 128'd0);
    chk("dirty_wb_address", {100'b0, m_wb_a}, 128'h4);
    chk("dirty_wb_data", m_wb_d, {32'h0BADBEEF, 32'hCAFEF00D, 32'h55663344, 32'hDEAD12EF});
    chk("dirty_rd_address", {100'b0, m_rd_a}, 128'h14);
    chk("dirty_busy_cycles", m_busy, 128'd9);
    chk("dirty_readdata", {96'b0, m_rdat}, 128'h13579BDF);

    // Re-fetch of the written-back block (victim now clean)
    run_req(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 0);
    exp_miss++; exp_hits++;
    chk("refetch_busy_cycles", m_busy, 128'd2);
    chk("refetch_no_writeback", {127'b0, m_saw_wb}, 128'd0);
    chk("refetch_readdata", {96'b0, m_rdat}, 128'hDEAD12EF);
`ifdef DCACHE_STATS_EN
    chk("stats_hit_count", {96'b0, HIT_COUNT}, exp_hits);
    chk("stats_miss_count", {96'b0, MISS_COUNT}, exp_miss);
`endif

    // Reset pulsed during ALLOCATE with the request still held
    mem_lat = 3;
    READ = 1; WRITE = 0; FUNCT3 = 3'b010; ADDRESS = 32'h140;
    begin
      logic seen;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge CLK);
        if (MEM_READ) begin
          seen = 1;
          break;
        end
      end
      chk("midalloc_reached_allocate", {127'b0, seen}, 128'd1);
    end
    #1 RESET = 0;
    #1;
    chk("midalloc_mem_read_drop", {127'b0, MEM_READ}, 128'd0);
    chk("midalloc_busywait", {127'b0, BUSYWAIT}, 128'd0);
`ifdef DCACHE_STATS_EN
    chk("midalloc_hit_count", {96'b0, HIT_COUNT}, 128'd0);
    chk("midalloc_miss_count", {96'b0, MISS_COUNT}, 128'd0);
`endif
    READ = 0; ADDRESS = 0;
    @(posedge CLK); #1 RESET = 1;
    @(posedge CLK); #1;

    run_req(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 0);
    chk("postrst_busy_cycles", m_busy, 128'd2);
    chk("postrst_readdata", {96'b0, m_rdat}, 128'hDEAD12EF);
`ifdef DCACHE_STATS_EN
    chk("postrst_hit_count", {96'b0, HIT_COUNT}, 128'd1);
    chk("postrst_miss_count", {96'b0, MISS_COUNT}, 128'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
